nios2_fp_cpu_oci_dct_sequencer: RTL and testbench
=================================================

// Module: nios2_fp_cpu_oci_dct_sequencer
// PURPOSE
//  Sequences the OCI debug-capture-trace (DCT) pack buffer: packs 2-bit trace items into a
//  30-bit shift buffer with a 4-bit item count, and hands full or flushed words to the
//  trace-memory writer over a valid/ready output slot. Also drives the test_ending /
//  test_has_ended pair consumed by the OCI test bench, so simulation end follows the last drained word.
// PARAMETERS
//  ITEM_W   2    bits per trace item
//  DEPTH    15   items per packed word (ITEM_W*DEPTH = 30 = BUF_W)
//  CNT_W    4    width of item counters (holds 0..DEPTH)
//  STALL_W  16   width of saturating stall counter
// PORTS
//  clk            in   1        single clock, all state on rising edge
//  reset          in   1        asynchronous, active-high reset
//  in_valid       in   1        trace item offered
//  in_data        in   ITEM_W   trace item
//  in_ready       out  1        item accepted when in_valid & in_ready
//  flush          in   1        1-cycle pulse: emit partial word
//  stop           in   1        1-cycle pulse: drain and end capture
//  arm            in   1        1-cycle pulse: leave ENDED, resume capture
//  out_valid      out  1        packed word held for writer
//  out_ready      in   1        writer takes word when out_valid & out_ready
//  out_data       out  BUF_W    packed word (oldest item in highest used slot)
//  out_count      out  CNT_W    items in out_data (1..DEPTH)
//  dct_buffer     out  BUF_W    live pack buffer
//  dct_count      out  CNT_W    live item count
//  test_ending    out  1        high while in DRAIN
//  test_has_ended out  1        high while in ENDED
//  stall_count    out  STALL_W  saturating count of cycles with in_valid & ~in_ready in FILL
// BEHAVIOUR
//  Reset: all outputs and regs 0, state FILL, flush_pend 0; buffered items discarded,
//   also when asserted mid-word or with out_valid high.
//  States: FILL -> (stop) DRAIN -> (buffer empty & ~out_valid) ENDED -> (arm) FILL.
//   stop in DRAIN/ENDED ignored; arm outside ENDED ignored; flush outside FILL ignored.
//  slot_free = ~out_valid | out_ready.
//  emit = slot_free & ((dct_count==DEPTH) | ((flush_pend|state==DRAIN) & dct_count!=0)).
//  On emit: out_data<=dct_buffer, out_count<=dct_count, out_valid<=1, buffer cleared.
//  On out_ready & out_valid without emit: out_valid<=0; out_data/out_count hold their last values.
//  out_data/out_count stable while out_valid & ~out_ready.
//  in_ready = (state==FILL) & ~flush_pend & (dct_count<DEPTH | emit). Combinational.
//  Accept: dct_buffer<={dct_buffer[BUF_W-ITEM_W-1:0],in_data}, dct_count+1.
//   Accept on emit cycle: dct_buffer<={zeros,in_data}, dct_count<=1 (full throughput).
//  Partial words are right-aligned: items in low out_count*ITEM_W bits, upper bits 0.
//  flush: sets flush_pend. flush_pend clears on the emit cycle, or on the next cycle if dct_count==0.
//   Items arriving while flush_pend is set are stalled, not merged into the partial word.
//  flush and stop in the same cycle: stop wins (DRAIN emits the partial word anyway).
//  DRAIN: no accepts; emit remaining partial word; ENDED when dct_count==0 & ~out_valid.
//  stall_count increments per stalled cycle in FILL, saturates at all-ones, cleared only by reset.
//  Latency: item to out_valid is 1 cycle after the DEPTH-th accept, if the slot is free.
// TESTING
//  1 Reset, out_ready=1, 15 back-to-back items 2'b01 -> out_valid 1 cycle later,
//    out_data=30'h15555555, out_count=15, dct_count=0.
//  2 30 items continuous, out_ready=0 until cycle 40 -> in_ready low after 2nd fill,
//    stall_count counts stalled cycles, first word unchanged, then both words in order.
//  3 3 items 3,2,1 then flush -> out_data=30'h39, out_count=3; in_ready low until emit.
//  4 5 items then stop, out_ready=1 -> test_ending high, partial word out_count=5,
//    then test_has_ended=1, in_ready=0; arm -> FILL, both flags 0.
//  5 Assert reset with dct_count=7 and out_valid=1 -> all outputs 0 immediately
//    (asynchronous), no word emitted afterwards.
//  6 flush with dct_count=0 -> no out_valid, flush_pend clears next cycle,
//    in_ready returns 1.

Source files
------------

// File: rtl/nios2_fp_cpu_oci_dct_sequencer.sv
// nios2_fp_cpu_oci_dct_sequencer
//   Packs 2-bit OCI trace items into a 30-bit shift buffer and hands full or
//   flushed words to the trace-memory writer through a one-entry valid/ready
//   slot. Also runs the FILL/DRAIN/ENDED sequence that drives test_ending and
//   test_has_ended, so capture end follows the last drained word.
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_data/in_ready  trace item input handshake
//   flush, stop, arm           1-cycle control pulses
//   out_valid/out_ready        packed word output handshake
//   out_data/out_count         packed word (right-aligned) and its item count
//   dct_buffer/dct_count       live pack buffer and item count
//   test_ending/test_has_ended high in DRAIN / ENDED
//   stall_count                saturating count of stalled input cycles in FILL
module nios2_fp_cpu_oci_dct_sequencer #(
   parameter int unsigned ITEM_W  = 2,
   parameter int unsigned DEPTH   = 15,
   parameter int unsigned CNT_W   = 4,
   parameter int unsigned STALL_W = 16,
   localparam int unsigned BUF_W  = ITEM_W * DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [ITEM_W-1:0]  in_data,
   output logic               in_ready,
   input  logic               flush,
   input  logic               stop,
   input  logic               arm,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BUF_W-1:0]   out_data,
   output logic [CNT_W-1:0]   out_count,
   output logic [BUF_W-1:0]   dct_buffer,
   output logic [CNT_W-1:0]   dct_count,
   output logic               test_ending,
   output logic               test_has_ended,
   output logic [STALL_W-1:0] stall_count
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      StFill  = 2'd0,
      StDrain = 2'd1,
      StEnded = 2'd2
   } state_e;

   state_e state;
   logic   flush_pend;
   logic   slot_free;
   logic   emit;
   logic   accept;
   logic   stalled;

   always_comb begin
      slot_free = ~out_valid | out_ready;
      emit      = slot_free & ((dct_count == FULL_CNT) |
                               ((flush_pend | (state == StDrain)) & (dct_count != '0)));
      // A full buffer still accepts on its emit cycle, giving full throughput.
      in_ready  = ~reset & (state == StFill) & ~flush_pend &
                  ((dct_count < FULL_CNT) | emit);
      accept    = in_valid & in_ready;
      stalled   = (state == StFill) & in_valid & ~in_ready;
   end

   assign test_ending    = (state == StDrain);
   assign test_has_ended = (state == StEnded);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= StFill;
         flush_pend  <= 1'b0;
         dct_buffer  <= '0;
         dct_count   <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_count   <= '0;
         stall_count <= '0;
      end else begin
         // Output slot: load on emit, otherwise release when the writer takes it.
         if (emit) begin
            out_data  <= dct_buffer;
            out_count <= dct_count;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         // Pack buffer: emitted contents are cleared; an item accepted on the
         // same cycle starts the next word.
         if (emit && accept) begin
            dct_buffer <= {{(BUF_W-ITEM_W){1'b0}}, in_data};
            dct_count  <= CNT_W'(1);
         end else if (emit) begin
            dct_buffer <= '0;
            dct_count  <= '0;
         end else if (accept) begin
            dct_buffer <= {dct_buffer[BUF_W-ITEM_W-1:0], in_data};
            dct_count  <= dct_count + CNT_W'(1);
         end

         // stop in the same cycle as flush wins; DRAIN emits the partial word anyway.
         if (flush && (state == StFill) && !stop) begin
            flush_pend <= 1'b1;
         end else if (flush_pend && (emit || (dct_count == '0))) begin
            flush_pend <= 1'b0;
         end

         if (stalled && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_W'(1);
         end

         unique case (state)
            StFill:  if (stop) state <= StDrain;
            StDrain: if ((dct_count == '0) && !out_valid) state <= StEnded;
            StEnded: if (arm) state <= StFill;
            default: state <= StFill;
         endcase
      end
   end

endmodule

// File: tb/tb_nios2_fp_cpu_oci_dct_sequencer.sv
module tb_nios2_fp_cpu_oci_dct_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [1:0]  in_data = 2'b00;
   logic        in_ready;
   logic        flush = 1'b0;
   logic        stop = 1'b0;
   logic        arm = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [29:0] out_data;
   logic [3:0]  out_count;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        test_ending;
   logic        test_has_ended;
   logic [15:0] stall_count;

   int n_cmp = 0;
   int n_bad = 0;

   nios2_fp_cpu_oci_dct_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .flush          (flush),
      .stop           (stop),
      .arm            (arm),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_count      (out_count),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended),
      .stall_count    (stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: live items as a queue (oldest first), the held word as value+count.
   localparam int M_FILL = 0, M_DRAIN = 1, M_ENDED = 2;
   int          m_items[$];
   int          m_state;
   bit          m_ov;
   bit          m_fp;
   int          m_stall;
   logic [29:0] m_wdata;
   int          m_wcnt;

   function automatic logic [29:0] m_pack();
      logic [29:0] v = '0;
      foreach (m_items[i]) v = (v << 2) | 30'(m_items[i]);
      return v;
   endfunction

   function automatic bit m_emit(bit ordy);
      int n = m_items.size();
      return (!m_ov || ordy) && (n == 15 || ((m_fp || m_state == M_DRAIN) && n != 0));
   endfunction

   function automatic bit m_rdy(bit ordy);
      return m_state == M_FILL && !m_fp && (m_items.size() < 15 || m_emit(ordy));
   endfunction

   function automatic void m_reset();
      m_items.delete();
      m_state = M_FILL;
      m_ov = 0; m_fp = 0; m_stall = 0; m_wdata = '0; m_wcnt = 0;
   endfunction

   function automatic void m_step();
      int n    = m_items.size();
      bit e    = m_emit(out_ready);
      bit rdy  = m_rdy(out_ready);
      bit ov0  = m_ov;
      bit nfp  = m_fp && !(e || n == 0);
      int nst  = m_state;
      if (m_state == M_FILL && in_valid && !rdy && m_stall < 65535) m_stall++;
      if (e) begin
         m_wdata = m_pack();
         m_wcnt  = n;
         m_ov    = 1;
         m_items.delete();
      end else if (out_ready) begin
         m_ov = 0;
      end
      if (in_valid && rdy) m_items.push_back(int'(in_data));
      if (flush && m_state == M_FILL && !stop) nfp = 1;
      if (m_state == M_FILL && stop) nst = M_DRAIN;
      else if (m_state == M_DRAIN && n == 0 && !ov0) nst = M_ENDED;
      else if (m_state == M_ENDED && arm) nst = M_FILL;
      m_fp = nfp;
      m_state = nst;
   endfunction

   task automatic compare_all();
      check("in_ready", 32'(in_ready), 32'(m_rdy(out_ready)));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("out_data", 32'(out_data), 32'(m_wdata));
      check("out_count", 32'(out_count), 32'(m_wcnt));
      check("dct_buffer", 32'(dct_buffer), 32'(m_pack()));
      check("dct_count", 32'(dct_count), 32'(m_items.size()));
      check("test_ending", 32'(test_ending), 32'(m_state == M_DRAIN));
      check("test_has_ended", 32'(test_has_ended), 32'(m_state == M_ENDED));
      check("stall_count", 32'(stall_count), 32'(m_stall));
   endtask

   // One cycle: drive at negedge, compare shortly after, advance model on posedge.
   task automatic drive(input bit iv, input logic [1:0] d, input bit fl, input bit st,
                        input bit ar, input bit ordy);
      in_valid = iv; in_data = d; flush = fl; stop = st; arm = ar; out_ready = ordy;
      #1;
      compare_all();
      @(posedge clk);
      m_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      in_valid = 0; flush = 0; stop = 0; arm = 0; out_ready = 0;
      reset = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_dct_count", 32'(dct_count), 32'd0);
      check("rst_dct_buffer", 32'(dct_buffer), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_stall", 32'(stall_count), 32'd0);
      check("rst_flags", 32'({test_ending, test_has_ended}), 32'd0);
      m_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // Fifteen back-to-back 2'b01 items form one full word.
      for (int i = 0; i < 15; i++) drive(1, 2'b01, 0, 0, 0, 1);
      drive(0, 2'b00, 0, 0, 0, 1);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_data", 32'(out_data), 32'h15555555);
      check("t1_count", 32'(out_count), 32'd15);
      check("t1_dct_count", 32'(dct_count), 32'd0);

      // Continuous input against a blocked writer, then release.
      do_reset();
      for (int c = 0; c < 50; c++) drive(1, 2'($urandom_range(3)), 0, 0, 0, c >= 40);
      for (int c = 0; c < 6; c++) drive(0, 2'b00, 0, 0, 0, 1);

      // Three items then flush: partial right-aligned word.
      do_reset();
      drive(1, 2'd3, 0, 0, 0, 1);
      drive(1, 2'd2, 0, 0, 0, 1);
      drive(1, 2'd1, 0, 0, 0, 1);
      drive(0, 2'd0, 1, 0, 0, 1);
      drive(1, 2'd0, 0, 0, 0, 1);
      check("t3_data", 32'(out_data), 32'h39);
      check("t3_count", 32'(out_count), 32'd3);
      drive(1, 2'd0, 0, 0, 0, 1);

      // Stop drains the partial word and ends capture; arm resumes.
      do_reset();
      for (int i = 0; i < 5; i++) drive(1, 2'($urandom_range(3)), 0, 0, 0, 1);
      drive(0, 2'd0, 0, 1, 0, 1);
      check("t4_ending", 32'(test_ending), 32'd1);
      for (int i = 0; i < 4; i++) drive(1, 2'd1, 0, 0, 0, 1);
      check("t4_ended", 32'(test_has_ended), 32'd1);
      check("t4_in_ready", 32'(in_ready), 32'd0);
      check("t4_word_cnt", 32'(out_count), 32'd5);
      drive(0, 2'd0, 0, 0, 1, 1);
      check("t4_flags", 32'({test_ending, test_has_ended}), 32'd0);

      // Reset mid-word with a word held in the slot.
      for (int i = 0; i < 22; i++) drive(1, 2'($urandom_range(3)), 0, 0, 0, 0);
      check("t5_pre_valid", 32'(out_valid), 32'd1);
      check("t5_pre_count", 32'(dct_count), 32'd7);
      do_reset();
      for (int i = 0; i < 4; i++) drive(0, 2'd0, 0, 0, 0, 1);

      // Flush on an empty buffer.
      drive(0, 2'd0, 1, 0, 0, 1);
      check("t6_stalled", 32'(in_ready), 32'd0);
      drive(1, 2'd2, 0, 0, 0, 1);
      check("t6_ready", 32'(in_ready), 32'd1);
      check("t6_no_word", 32'(out_valid), 32'd0);
      drive(1, 2'd2, 0, 0, 0, 1);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(999) < 3) do_reset();
         else drive($urandom_range(99) < 70, 2'($urandom_range(3)),
                    $urandom_range(99) < 5, $urandom_range(99) < 2,
                    $urandom_range(99) < 10, $urandom_range(99) < 60);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
